// File: rtl/fft_tw_pkg.sv
// Shared twiddle definitions: Q1.16 constants, complex sample type, FSM encoding and the
// elaboration-time quarter-wave table builder.
package fft_tw_pkg;

    localparam int unsigned      TW_DW    = 18;
    localparam logic [TW_DW-1:0] TW_ONE   = 18'h10000;
    localparam real              TW_PI    = 3.14159265358979323846;
    localparam real              TW_SCALE = 65536.0;

    typedef struct packed {
        logic signed [TW_DW-1:0] re;
        logic signed [TW_DW-1:0] im;
    } tw_cplx_t;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } tw_state_e;

    // Floor quantisation; reproduces the reference twiddle set bit-exactly.
    function automatic logic signed [TW_DW-1:0] tw_quant(input real x);
        return TW_DW'($rtoi($floor(x)));
    endfunction

    // Entry a of the quarter-wave table for an N = 2^log2n point transform.
    function automatic tw_cplx_t tw_quarter_entry(input int unsigned log2n,
                                                  input int unsigned a);
        tw_cplx_t e;
        real      ang;
        ang = 2.0 * TW_PI * real'(a) / real'(32'd1 << log2n);
        if (a == 0) begin
            e.re = TW_ONE;
            e.im = '0;
        end else begin
            e.re = tw_quant(TW_SCALE * $cos(ang));
            e.im = tw_quant(-TW_SCALE * $sin(ang));
        end
        return e;
    endfunction

endpackage

// File: rtl/fft_tw_rom.sv
// Quarter-wave twiddle ROM with quadrant rotation and optional conjugation; its registered
// output is the second pipeline stage of the twiddle sequencer.
module fft_tw_rom
    import fft_tw_pkg::*;
#(
    parameter int unsigned LOG2N = 7,
    parameter int unsigned DW    = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [LOG2N-1:0] i_k,
    input  logic             i_last,
    input  logic             i_conj,
    output logic             o_valid,
    output logic [DW-1:0]    o_re,
    output logic [DW-1:0]    o_im,
    output logic [LOG2N-1:0] o_k,
    output logic             o_last
);

    localparam int unsigned QN = 1 << (LOG2N - 2);

    tw_cplx_t                w_tab [QN];
    tw_cplx_t                w_ent;
    logic [1:0]              w_q;
    logic [LOG2N-3:0]        w_a;
    logic signed [TW_DW-1:0] w_re;
    logic signed [TW_DW-1:0] w_im;
    logic signed [TW_DW-1:0] w_im_c;

    logic                    r_valid;
    logic [DW-1:0]           r_re;
    logic [DW-1:0]           r_im;
    logic [LOG2N-1:0]        r_k;
    logic                    r_last;

    for (genvar g = 0; g < QN; g++) begin : g_tab
        localparam tw_cplx_t Entry = tw_quarter_entry(LOG2N, g);
        assign w_tab[g] = Entry;
    end

    assign w_q   = i_k[LOG2N-1 -: 2];
    assign w_a   = i_k[LOG2N-3:0];
    assign w_ent = w_tab[w_a];

    // Each quadrant is the first-quadrant value multiplied by -j.
    always_comb begin
        w_re = w_ent.re;
        w_im = w_ent.im;
        unique case (w_q)
            2'b00: begin
                w_re = w_ent.re;
                w_im = w_ent.im;
            end
            2'b01: begin
                w_re = w_ent.im;
                w_im = -w_ent.re;
            end
            2'b10: begin
                w_re = -w_ent.re;
                w_im = -w_ent.im;
            end
            2'b11: begin
                w_re = -w_ent.im;
                w_im = w_ent.re;
            end
        endcase
        w_im_c = i_conj ? -w_im : w_im;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_re    <= '0;
            r_im    <= '0;
            r_k     <= '0;
            r_last  <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_re   <= DW'(w_re);
                r_im   <= DW'(w_im_c);
                r_k    <= i_k;
                r_last <= i_last;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_re    = r_re;
    assign o_im    = r_im;
    assign o_k     = r_k;
    assign o_last  = r_last;

endmodule

// File: rtl/fft_twiddle_seq.sv
// Sequenced twiddle generator: streams W_N^k for k = base + i*step (mod N) per command.
// Define FFT_TW_CONJ_EN to add the inv port that conjugates a whole command (IFFT use).
module fft_twiddle_seq
    import fft_tw_pkg::*;
#(
    parameter int unsigned LOG2N = 7,
    parameter int unsigned DW    = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LOG2N-1:0] base_k,
    input  logic [LOG2N-1:0] step_k,
    input  logic [LOG2N:0]   cnt,
`ifdef FFT_TW_CONJ_EN
    input  logic             inv,
`endif
    output logic             busy,
    output logic             tw_valid,
    input  logic             tw_ready,
    output logic [DW-1:0]    tw_re,
    output logic [DW-1:0]    tw_im,
    output logic [LOG2N-1:0] tw_k,
    output logic             tw_last
);

    localparam logic [LOG2N:0] IdxOne = 1;

    tw_state_e        r_state;
    tw_state_e        w_state_nxt;
    logic [LOG2N-1:0] r_k;
    logic [LOG2N-1:0] r_step;
    logic [LOG2N:0]   r_cnt;
    logic [LOG2N:0]   r_idx;
    logic             r_a_valid;
    logic [LOG2N-1:0] r_a_k;
    logic             r_a_last;
    logic             w_adv;
    logic             w_launch;
    logic             w_issue;
    logic             w_done;
    logic             w_conj;

    assign w_adv    = ~tw_valid | tw_ready;
    assign w_launch = (r_state == StIdle) & start & (cnt != '0);
    assign w_issue  = (r_state == StRun) & (r_idx != r_cnt);
    assign w_done   = tw_valid & tw_ready & tw_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: if (w_launch) w_state_nxt = StRun;
            StRun:  if (w_done)   w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        busy = (r_state == StRun);
    end

    // Exponent accumulator wraps mod N through natural LOG2N-bit overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k    <= '0;
            r_step <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
        end else if (w_launch) begin
            r_k    <= base_k;
            r_step <= step_k;
            r_cnt  <= cnt;
            r_idx  <= '0;
        end else if (w_adv && w_issue) begin
            r_k    <= r_k + r_step;
            r_idx  <= r_idx + IdxOne;
        end
    end

`ifdef FFT_TW_CONJ_EN
    logic r_inv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inv <= 1'b0;
        end else if (w_launch) begin
            r_inv <= inv;
        end
    end

    assign w_conj = r_inv;
`else
    assign w_conj = 1'b0;
`endif

    // Stage A: exponent and end-of-command marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
            r_a_k     <= '0;
            r_a_last  <= 1'b0;
        end else if (w_adv) begin
            r_a_valid <= w_issue;
            if (w_issue) begin
                r_a_k    <= r_k;
                r_a_last <= (r_idx == r_cnt - IdxOne);
            end
        end
    end

    fft_tw_rom #(
        .LOG2N(LOG2N),
        .DW   (DW)
    ) u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_adv),
        .i_valid(r_a_valid),
        .i_k    (r_a_k),
        .i_last (r_a_last),
        .i_conj (w_conj),
        .o_valid(tw_valid),
        .o_re   (tw_re),
        .o_im   (tw_im),
        .o_k    (tw_k),
        .o_last (tw_last)
    );

endmodule

// File: tb/tb_fft_twiddle_seq.sv
// Directed scoreboard bench for fft_twiddle_seq at LOG2N=3 (exact values) and LOG2N=7
// (real-math model, +/-1 LSB); the conjugation step needs FFT_TW_CONJ_EN.
module tb_fft_twiddle_seq;

    localparam real PI = 3.14159265358979323846;

    typedef struct {
        int          k;
        logic [17:0] re_x;
        logic [17:0] im_x;
        int          re_m;
        int          im_m;
        bit          last;
        bit          exact;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sel7  = 1'b0;
    logic        ready = 1'b1;
    logic [6:0]  base  = '0;
    logic [6:0]  step  = '0;
    logic [7:0]  cnt   = '0;
`ifdef FFT_TW_CONJ_EN
    logic        inv   = 1'b0;
`endif
    logic        start3, start7;
    logic        busy3, valid3, last3, busy7, valid7, last7;
    logic [17:0] re3, im3, re7, im7;
    logic [2:0]  k3;
    logic [6:0]  k7;
    logic        o_busy, o_valid, o_last;
    logic [17:0] o_re, o_im;
    logic [6:0]  o_k;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    logic [17:0] t3_re [8] = '{18'h10000, 18'h0B504, 18'h00000, 18'h34AFB,
                               18'h30000, 18'h34AFC, 18'h00000, 18'h0B505};
    logic [17:0] t3_im [8] = '{18'h00000, 18'h34AFB, 18'h30000, 18'h34AFC,
                               18'h00000, 18'h0B505, 18'h10000, 18'h0B504};

    always #5 clk = ~clk;

    assign start3  = start & ~sel7;
    assign start7  = start & sel7;
    assign o_busy  = sel7 ? busy7 : busy3;
    assign o_valid = sel7 ? valid7 : valid3;
    assign o_last  = sel7 ? last7 : last3;
    assign o_re    = sel7 ? re7 : re3;
    assign o_im    = sel7 ? im7 : im3;
    assign o_k     = sel7 ? k7 : {4'b0000, k3};

    fft_twiddle_seq #(.LOG2N(3), .DW(18)) u_dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start3),
        .base_k  (base[2:0]),
        .step_k  (step[2:0]),
        .cnt     (cnt[3:0]),
`ifdef FFT_TW_CONJ_EN
        .inv     (inv),
`endif
        .busy    (busy3),
        .tw_valid(valid3),
        .tw_ready(ready),
        .tw_re   (re3),
        .tw_im   (im3),
        .tw_k    (k3),
        .tw_last (last3)
    );

    fft_twiddle_seq #(.LOG2N(7), .DW(18)) u_dut7 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start7),
        .base_k  (base),
        .step_k  (step),
        .cnt     (cnt),
`ifdef FFT_TW_CONJ_EN
        .inv     (inv),
`endif
        .busy    (busy7),
        .tw_valid(valid7),
        .tw_ready(ready),
        .tw_re   (re7),
        .tw_im   (im7),
        .tw_k    (k7),
        .tw_last (last7)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp);
        int d;
        d = obs - exp;
        total++;
        assert (d >= -1 && d <= 1) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d (+/-1)", tag, obs, exp);
        end
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    function automatic void push_cmd(input int log2n, input int b, input int s, input int c,
                                     input bit iv);
        int n;
        n = 1 << log2n;
        for (int i = 0; i < c; i++) begin
            exp_t e;
            real  ang;
            e.k     = (b + i * s) % n;
            e.last  = (i == c - 1);
            e.exact = (log2n == 3);
            ang     = 2.0 * PI * real'(e.k) / real'(n);
            e.re_m  = rnd(65536.0 * $cos(ang));
            e.im_m  = rnd(-65536.0 * $sin(ang));
            if (iv) e.im_m = -e.im_m;
            e.re_x  = t3_re[e.k % 8];
            e.im_x  = iv ? 18'(18'h0 - t3_im[e.k % 8]) : t3_im[e.k % 8];
            exp_q.push_back(e);
        end
    endfunction

    task automatic start_cmd(input int log2n, input int b, input int s, input int c,
                             input bit iv);
        @(posedge clk);
        #1;
        base  = 7'(b);
        step  = 7'(s);
        cnt   = 8'(c);
`ifdef FFT_TW_CONJ_EN
        inv   = iv;
`endif
        ready = 1'b1;
        start = 1'b1;
        if (c != 0) push_cmd(log2n, b, s, c, iv);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic expect_latency();
        @(negedge clk);
        chk("lat_busy_e0", o_busy, 1);
        chk("lat_valid_e0", o_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat_valid_e1", o_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat_valid_e2", o_valid, 1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_re"}, o_re, 0);
        chk({tag, "_im"}, o_im, 0);
        chk({tag, "_k"}, o_k, 0);
        chk({tag, "_last"}, o_last, 0);
    endtask

    // Entered and left at a negedge; pops one expected word per accepted handshake.
    task automatic run_stream(input int budget, input bit toggle, input int max_pops,
                              input bit poke_last);
        int          cyc;
        int          pops;
        bit          hold;
        logic [17:0] h_re, h_im;
        logic [6:0]  h_k;
        logic        h_last;
        exp_t        e;
        cyc  = 0;
        pops = 0;
        hold = 1'b0;
        while (exp_q.size() != 0 && pops < max_pops && cyc < budget) begin
            if (hold) begin
                chk("hold_valid", o_valid, 1);
                chk("hold_re", o_re, h_re);
                chk("hold_im", o_im, h_im);
                chk("hold_k", o_k, h_k);
                chk("hold_last", o_last, h_last);
            end
            hold = 1'b0;
            if (!toggle) chk("no_bubble", o_valid, 1);
            if (o_valid && ready) begin
                e = exp_q.pop_front();
                pops++;
                chk($sformatf("k[%0d]", e.k), o_k, e.k);
                chk($sformatf("last[k=%0d]", e.k), o_last, e.last);
                if (e.exact) begin
                    chk($sformatf("re[k=%0d]", e.k), o_re, e.re_x);
                    chk($sformatf("im[k=%0d]", e.k), o_im, e.im_x);
                end else begin
                    chk_tol($sformatf("re7[k=%0d]", e.k), int'($signed(o_re)), e.re_m);
                    chk_tol($sformatf("im7[k=%0d]", e.k), int'($signed(o_im)), e.im_m);
                end
                if (poke_last && e.last) start = 1'b1;
            end else if (o_valid) begin
                hold   = 1'b1;
                h_re   = o_re;
                h_im   = o_im;
                h_k    = o_k;
                h_last = o_last;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            ready = toggle ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk("stream_budget", cyc < budget, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state on both instances.
        repeat (2) @(negedge clk);
        sel7 = 1'b0;
        #1;
        chk_idle("rst3");
        sel7 = 1'b1;
        #1;
        chk_idle("rst7");
        sel7 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Full circle at N=8 with latency check.
        start_cmd(3, 0, 1, 8, 1'b0);
        expect_latency();
        run_stream(40, 1'b0, 1000, 1'b0);
        chk("done1_busy", o_busy, 0);
        chk("done1_valid", o_valid, 0);

        // Wrapping stride: k = 6, 1, 4, 7.
        start_cmd(3, 6, 3, 4, 1'b0);
        expect_latency();
        run_stream(40, 1'b0, 1000, 1'b0);
        chk("done2_busy", o_busy, 0);

        // Backpressure at N=128, odd stride visits every exponent.
        sel7 = 1'b1;
        start_cmd(7, 5, 3, 128, 1'b0);
        @(negedge clk);
        run_stream(2000, 1'b1, 1000, 1'b0);
        ready = 1'b1;
        @(negedge clk);
        chk("done3_busy", o_busy, 0);
        chk("done3_valid", o_valid, 0);
        sel7 = 1'b0;

        // cnt=0 start is ignored.
        start_cmd(3, 2, 1, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("cnt0_busy", o_busy, 0);
            chk("cnt0_valid", o_valid, 0);
        end

        // Starts while busy (mid-run and on the final acceptance) are ignored.
        start_cmd(3, 0, 1, 8, 1'b0);
        expect_latency();
        run_stream(20, 1'b0, 2, 1'b0);
        base  = 7'd3;
        step  = 7'd2;
        cnt   = 8'd5;
        start = 1'b1;
        run_stream(40, 1'b0, 1000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busy_start_busy", o_busy, 0);
            chk("busy_start_valid", o_valid, 0);
        end

        // Async reset while word i=5 is presented.
        start_cmd(3, 0, 1, 8, 1'b0);
        expect_latency();
        run_stream(40, 1'b0, 5, 1'b0);
        chk("pre_reset_k", o_k, 5);
        rst_n = 1'b0;
        #1;
        chk_idle("midrst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        start_cmd(3, 0, 1, 8, 1'b0);
        expect_latency();
        run_stream(40, 1'b0, 1000, 1'b0);
        chk("done5_busy", o_busy, 0);

`ifdef FFT_TW_CONJ_EN
        // Conjugated single word: k=1 -> (0x0B504, 0x0B505).
        start_cmd(3, 1, 1, 1, 1'b1);
        expect_latency();
        run_stream(20, 1'b0, 1000, 1'b0);
        chk("done6_busy", o_busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
